// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
//
// Sequences a two-layer convolution engine. One start request runs every
// output channel of layer 1 and then every output channel of layer 2. Each
// channel goes through the same steps:
//   LOAD  - one cycle that loads the bias/coefficients for out_c
//   CONV  - convolution results are stored to consecutive addresses
//           0..CHANNEL_SIZE
//   POOL  - pooling runs until the datapath reports pool_done
//   NEXT  - one cycle that selects the next channel or layer, or finishes
// A final FIN cycle raises done for one cycle and then returns to IDLE.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-low reset
//   start       single-cycle request; honoured only in IDLE
//   conv_valid  datapath has a convolution result this cycle (used in CONV)
//   pool_done   datapath finished pooling this channel (used in POOL)
//   busy        high in LOAD, CONV, POOL and NEXT
//   done        single-cycle pulse in FIN
//   layer_sel   0 = layer 1, 1 = layer 2
//   c_load      single-cycle coefficient load strobe (LOAD)
//   conv        convolution enable level (CONV)
//   store       feature-map write strobe, equal to conv_valid while in CONV
//   pool        pooling enable level (POOL)
//   cout_done   single-cycle pulse when the channel's pooling completes
//   out_c       current output-channel index
//   w_addr      feature-map write address
//   state_dbg   current FSM state encoding, for observation only
//
// Handshake: conv_valid and pool_done are one-cycle qualifiers with no
// back-pressure. A cycle with conv_valid=1 in CONV is exactly one store, and
// a cycle with pool_done=1 in POOL ends pooling. Either input outside its own
// state is ignored. In CONV, pool_done is ignored even when it arrives
// together with conv_valid.
// -----------------------------------------------------------------------------
module layer_scheduler #(
    parameter int unsigned CHANNEL_SIZE = 783,
    parameter int unsigned OC_L1        = 7,
    parameter int unsigned OC_L2        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       conv_valid,
    input  logic       pool_done,
    output logic       busy,
    output logic       done,
    output logic       layer_sel,
    output logic       c_load,
    output logic       conv,
    output logic       store,
    output logic       pool,
    output logic       cout_done,
    output logic [3:0] out_c,
    output logic [9:0] w_addr,
    output logic [2:0] state_dbg
);

    localparam logic [9:0] LAST_ADDR = 10'(CHANNEL_SIZE);
    localparam logic [3:0] LAST_L1   = 4'(OC_L1);
    localparam logic [3:0] LAST_L2   = 4'(OC_L2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CONV = 3'd2,
        S_POOL = 3'd3,
        S_NEXT = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       layer_sel_q, layer_sel_d;
    logic [3:0] out_c_q, out_c_d;
    logic [9:0] w_addr_q, w_addr_d;
    logic [3:0] last_oc;

    // State and counter registers. Reset returns everything to zero at once,
    // so an interrupted sequence leaves no trace and never pulses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            layer_sel_q <= 1'b0;
            out_c_q     <= 4'd0;
            w_addr_q    <= 10'd0;
        end else begin
            state_q     <= state_d;
            layer_sel_q <= layer_sel_d;
            out_c_q     <= out_c_d;
            w_addr_q    <= w_addr_d;
        end
    end

    // Last channel index of whichever layer is active.
    assign last_oc = layer_sel_q ? LAST_L2 : LAST_L1;

    // Next-state, counter updates and decoded outputs.
    always_comb begin
        state_d     = state_q;
        layer_sel_d = layer_sel_q;
        out_c_d     = out_c_q;
        w_addr_d    = w_addr_q;
        busy        = 1'b0;
        done        = 1'b0;
        c_load      = 1'b0;
        conv        = 1'b0;
        store       = 1'b0;
        pool        = 1'b0;
        cout_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // layer_sel/out_c from the previous run are held here until
                // a new start clears them.
                if (start) begin
                    state_d     = S_LOAD;
                    layer_sel_d = 1'b0;
                    out_c_d     = 4'd0;
                    w_addr_d    = 10'd0;
                end
            end

            S_LOAD: begin
                busy    = 1'b1;
                c_load  = 1'b1;
                state_d = S_CONV;
            end

            S_CONV: begin
                busy  = 1'b1;
                conv  = 1'b1;
                store = conv_valid;
                if (conv_valid) begin
                    // The write at LAST_ADDR is the channel's last. The
                    // address wraps to zero here and nowhere else.
                    if (w_addr_q == LAST_ADDR) begin
                        w_addr_d = 10'd0;
                        state_d  = S_POOL;
                    end else begin
                        w_addr_d = w_addr_q + 10'd1;
                    end
                end
            end

            S_POOL: begin
                busy = 1'b1;
                pool = 1'b1;
                if (pool_done) begin
                    cout_done = 1'b1;
                    state_d   = S_NEXT;
                end
            end

            S_NEXT: begin
                busy = 1'b1;
                if (out_c_q < last_oc) begin
                    out_c_d = out_c_q + 4'd1;
                    state_d = S_LOAD;
                end else if (!layer_sel_q) begin
                    layer_sel_d = 1'b1;
                    out_c_d     = 4'd0;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign layer_sel = layer_sel_q;
    assign out_c     = out_c_q;
    assign w_addr    = w_addr_q;
    assign state_dbg = state_q;

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter CHANNEL_SIZE, default 783: last write address of one output-channel feature map.
REQ-002 Parameter OC_L1, default 7: last output-channel index of layer 1.
REQ-003 Parameter OC_L2, default 7: last output-channel index of layer 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to run the full two-layer sequence.
REQ-007 conv_valid  input  1  datapath has a convolution result ready this cycle.
REQ-008 pool_done  input  1  datapath finished pooling the current channel.
REQ-009 busy  output  1  high from sequence acceptance until done.
REQ-010 done  output  1  single-cycle pulse at sequence completion.
REQ-011 layer_sel  output  1  0 = layer 1 active, 1 = layer 2 active.
REQ-012 c_load  output  1  single-cycle bias/coefficient load strobe for out_c.
REQ-013 conv  output  1  convolution enable level.
REQ-014 store  output  1  write strobe for the feature-map memory.
REQ-015 pool  output  1  pooling enable level.
REQ-016 cout_done  output  1  single-cycle pulse when a channel completes pooling.
REQ-017 out_c  output  4  current output-channel index.
REQ-018 w_addr  output  10  feature-map write address.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, CONV, POOL, NEXT, FIN.
REQ-020 IDLE: start=1 -> LOAD next cycle with layer_sel=0, out_c=0, w_addr=0; start ignored in all other states.
REQ-021 LOAD SHALL last exactly one cycle with c_load=1, then go to CONV.
REQ-022 CONV: conv=1; store = conv_valid (combinational, same cycle); each store increments w_addr after the write.
REQ-023 Store at w_addr==CHANNEL_SIZE SHALL be the channel's last: w_addr returns to 0, FSM goes to POOL next cycle.
REQ-024 w_addr SHALL never exceed CHANNEL_SIZE; wrap is CHANNEL_SIZE -> 0 only.
REQ-025 POOL: pool=1 until pool_done=1; that cycle cout_done=1, FSM -> NEXT.
REQ-026 pool_done or conv_valid outside its own state SHALL be ignored with no state change.
REQ-027 NEXT (one cycle): out_c < last index of active layer -> out_c+1, go to LOAD; else if layer_sel=0 -> layer_sel=1, out_c=0, go to LOAD; else go to FIN.
REQ-028 FIN SHALL last one cycle with done=1, busy=0, then IDLE; layer_sel and out_c hold until next start.
REQ-029 busy SHALL be 1 in LOAD, CONV, POOL, NEXT; 0 in IDLE and FIN.
REQ-030 c_load, conv, pool, cout_done, done SHALL be mutually exclusive; store only with conv.
REQ-031 Minimum channel latency: 1 (LOAD) + CHANNEL_SIZE+1 (CONV, conv_valid every cycle) + 1 (POOL, immediate pool_done) + 1 (NEXT) cycles.
REQ-032 conv_valid and pool_done asserted together in CONV: only the store is taken.

Reset
REQ-033 rst=0 SHALL immediately force IDLE and all outputs to 0 (out_c=0, w_addr=0, layer_sel=0), regardless of clock.
REQ-034 Reset mid-sequence SHALL abandon it; no done pulse; new start required after release.
REQ-035 First start is accepted on the first rising edge with rst=1.

Verification
REQ-036 Reset then start pulse -> c_load=1 next cycle, out_c=0, layer_sel=0, busy=1.
REQ-037 CONV with conv_valid held 1 -> exactly 784 store pulses, w_addr 0..783, then pool=1 with w_addr=0.
REQ-038 conv_valid toggling 1/0 -> store mirrors it, w_addr advances only on store cycles; 784 stores total.
REQ-039 Full run, immediate pool_done -> 8 cout_done with layer_sel=0 (out_c 0..7), 8 with layer_sel=1, then one done pulse, busy=0.
REQ-040 rst=0 during layer 2, out_c=3, w_addr=100 -> all outputs 0 asynchronously; no done; fresh start restarts at layer_sel=0, out_c=0.
REQ-041 start during busy and pool_done during CONV -> no effect on state, counters or outputs.
